// File: rtl/imsic_msi_ingress.sv
// MSI ingress for an IMSIC: synchronises per-port 4-phase MSI requests, queues them
// in a small FIFO and folds validated MSIs into the per-file eip pending registers.
module imsic_msi_ingress #(
  parameter int NR_INTP_FILES  = 7,
  parameter int XLEN           = 64,
  parameter int NR_SRC         = 256,
  parameter int NR_HARTS_WIDTH = 2,
  parameter int NR_PORTS       = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rstn,
  input  logic [NR_HARTS_WIDTH-1:0]                              hart_id,
  input  logic [NR_PORTS-1:0]                                    i_msi_req,
  input  logic [NR_PORTS*(NR_HARTS_WIDTH+$clog2(NR_INTP_FILES)+$clog2(NR_SRC))-1:0] i_msi_info,
  output logic [NR_PORTS-1:0]                                    o_msi_ack,
  input  logic                                                   i_claim_vld,
  input  logic [$clog2(NR_INTP_FILES)-1:0]                       i_claim_file,
  input  logic [$clog2(NR_SRC)-1:0]                              i_claim_id,
  input  logic [NR_INTP_FILES*((NR_SRC+XLEN-1)/XLEN)-1:0]        i_sw_wr,
  input  logic [NR_INTP_FILES*((NR_SRC+XLEN-1)/XLEN)*XLEN-1:0]   i_sw_data,
  output logic [NR_INTP_FILES*((NR_SRC+XLEN-1)/XLEN)*XLEN-1:0]   o_eip,
  output logic [$clog2(FIFO_DEPTH):0]                            o_fifo_cnt,
  output logic [7:0]                                             o_drop_cnt
);

  localparam int NR_SRC_WIDTH    = $clog2(NR_SRC);
  localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES);
  localparam int NR_REG          = (NR_SRC + XLEN - 1) / XLEN;
  localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH;
  localparam int NR_REGS_ALL     = NR_INTP_FILES * NR_REG;
  localparam int EIP_W           = NR_REGS_ALL * XLEN;
  localparam int EIP_IDX_W       = $clog2(EIP_W);
  localparam int AW              = $clog2(FIFO_DEPTH);
  localparam int CNT_W           = AW + 1;
  localparam int PTR_W           = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  // Handshake: the sender raises req with info held stable; ack rises once the
  // MSI sits in the FIFO; the sender drops req; ack falls after req_s falls.
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} port_state_e;

  port_state_e                state_q [NR_PORTS];
  port_state_e                state_d [NR_PORTS];
  logic [SYNC_STAGES-1:0]     sync_q  [NR_PORTS];
  logic [NR_PORTS-1:0]        req_s;
  logic [NR_PORTS-1:0]        eligible;
  logic [NR_PORTS-1:0]        grant;
  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           grant_idx;
  logic                       push;
  int                         cand;

  logic [MSI_INFO_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [CNT_W-1:0]           cnt_q;
  logic                       fifo_full;
  logic                       stall;
  logic                       pop;
  logic [MSI_INFO_WIDTH-1:0]  push_data;
  logic [MSI_INFO_WIDTH-1:0]  head;
  logic [NR_HARTS_WIDTH-1:0]  head_hart;
  logic [INTP_FILE_WIDTH-1:0] head_file;
  logic [NR_SRC_WIDTH-1:0]    head_id;
  logic                       head_valid;
  logic [EIP_IDX_W-1:0]       msi_bit_idx;
  logic                       claim_valid;
  logic [EIP_IDX_W-1:0]       claim_bit_idx;
  logic [EIP_W-1:0]           eip_q;
  logic [EIP_W-1:0]           eip_d;
  logic [7:0]                 drop_q;

  // Request synchronisers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < NR_PORTS; p++) sync_q[p] <= '0;
    end else begin
      for (int p = 0; p < NR_PORTS; p++)
        sync_q[p] <= {sync_q[p][SYNC_STAGES-2:0], i_msi_req[p]};
    end
  end

  always_comb begin
    req_s    = '0;
    eligible = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      req_s[p]    = sync_q[p][SYNC_STAGES-1];
      eligible[p] = req_s[p] && (state_q[p] != ST_ACK);
    end
  end

  // Round-robin arbiter; a full FIFO refuses every push even if it pops this cycle.
  assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    push      = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand      = 0;
    for (int i = 0; i < NR_PORTS; i++) begin
      cand = (int'(rr_ptr) + i) % NR_PORTS;
      if (!push && eligible[cand] && !fifo_full) begin
        push      = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
    if (push) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant_idx == PTR_W'(NR_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Per-port handshake FSMs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < NR_PORTS; p++) state_q[p] <= ST_IDLE;
    end else begin
      for (int p = 0; p < NR_PORTS; p++) state_q[p] <= state_d[p];
    end
  end

  always_comb begin
    o_msi_ack = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      state_d[p] = state_q[p];
      case (state_q[p])
        ST_IDLE: if (req_s[p]) state_d[p] = grant[p] ? ST_ACK : ST_WAIT;
        ST_WAIT: begin
          if (!req_s[p])     state_d[p] = ST_IDLE;
          else if (grant[p]) state_d[p] = ST_ACK;
        end
        ST_ACK:  if (!req_s[p]) state_d[p] = ST_IDLE;
        default: state_d[p] = ST_IDLE;
      endcase
      o_msi_ack[p] = (state_q[p] == ST_ACK);
    end
  end

  // MSI FIFO; CSR accesses to eip take priority and hold off the pop.
  assign push_data = i_msi_info[grant_idx*MSI_INFO_WIDTH +: MSI_INFO_WIDTH];
  assign stall     = i_claim_vld | (|i_sw_wr);
  assign pop       = (cnt_q != '0) && !stall;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign head_hart  = head[MSI_INFO_WIDTH-1 -: NR_HARTS_WIDTH];
  assign head_file  = head[NR_SRC_WIDTH +: INTP_FILE_WIDTH];
  assign head_id    = head[NR_SRC_WIDTH-1:0];
  assign head_valid = (head_hart == hart_id) && (int'(head_file) < NR_INTP_FILES) &&
                      (head_id != '0) && (int'(head_id) < NR_SRC);
  assign msi_bit_idx = EIP_IDX_W'((int'(head_file) * NR_REG + int'(head_id) / XLEN) * XLEN
                                  + int'(head_id) % XLEN);

  assign claim_valid   = i_claim_vld && (int'(i_claim_file) < NR_INTP_FILES) &&
                         (i_claim_id != '0) && (int'(i_claim_id) < NR_SRC);
  assign claim_bit_idx = EIP_IDX_W'((int'(i_claim_file) * NR_REG + int'(i_claim_id) / XLEN) * XLEN
                                    + int'(i_claim_id) % XLEN);

  // Pending bits: software write, then claim clear; an MSI set only happens when neither is active.
  always_comb begin
    eip_d = eip_q;
    for (int r = 0; r < NR_REGS_ALL; r++)
      if (i_sw_wr[r]) eip_d[r*XLEN +: XLEN] = i_sw_data[r*XLEN +: XLEN];
    if (claim_valid)        eip_d[claim_bit_idx] = 1'b0;
    if (pop && head_valid)  eip_d[msi_bit_idx]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eip_q  <= '0;
      drop_q <= '0;
    end else begin
      eip_q <= eip_d;
      if (pop && !head_valid && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end
  end

  assign o_eip      = eip_q;
  assign o_fifo_cnt = cnt_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_imsic_msi_ingress.sv
// Directed bench for imsic_msi_ingress: handshake latency, arbitration, back-pressure,
// drop counting, CSR write/claim ordering and reset behaviour.
module tb_imsic_msi_ingress;

  localparam int MIW   = 13;
  localparam int NREG  = 4;
  localparam int NREGS = 28;
  localparam int EIP_W = NREGS * 64;

  logic               clk = 1'b0;
  logic               rstn;
  logic [1:0]         hart_id;
  logic [1:0]         i_msi_req;
  logic [2*MIW-1:0]   i_msi_info;
  logic [1:0]         o_msi_ack;
  logic               i_claim_vld;
  logic [2:0]         i_claim_file;
  logic [7:0]         i_claim_id;
  logic [NREGS-1:0]   i_sw_wr;
  logic [EIP_W-1:0]   i_sw_data;
  logic [EIP_W-1:0]   o_eip;
  logic [2:0]         o_fifo_cnt;
  logic [7:0]         o_drop_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_reg [NREGS];

  always #5 clk = ~clk;

  imsic_msi_ingress dut (
    .clk          (clk),
    .rstn         (rstn),
    .hart_id      (hart_id),
    .i_msi_req    (i_msi_req),
    .i_msi_info   (i_msi_info),
    .o_msi_ack    (o_msi_ack),
    .i_claim_vld  (i_claim_vld),
    .i_claim_file (i_claim_file),
    .i_claim_id   (i_claim_id),
    .i_sw_wr      (i_sw_wr),
    .i_sw_data    (i_sw_data),
    .o_eip        (o_eip),
    .o_fifo_cnt   (o_fifo_cnt),
    .o_drop_cnt   (o_drop_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_eip(input string tag);
    logic [EIP_W-1:0] e;
    int bad;
    bad = 0;
    for (int r = 0; r < NREGS; r++) begin
      e[r*64 +: 64] = exp_reg[r];
      if (o_eip[r*64 +: 64] !== exp_reg[r] && bad == 0) bad = r + 1;
    end
    if (bad == 0) bad = 1;
    checks++;
    assert (o_eip === e) else begin
      errors++;
      $error("FAIL %s reg%0d observed=%0h expected=%0h", tag, bad - 1,
             o_eip[(bad-1)*64 +: 64], exp_reg[bad-1]);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < NREGS; r++) exp_reg[r] = '0;
  endtask

  function automatic logic [MIW-1:0] msi(input int h, input int f, input int id);
    return {h[1:0], f[2:0], id[7:0]};
  endfunction

  task automatic wait_ack(input int p, input logic v, input int bound, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (n < bound && !ok) begin
      tick(1);
      n++;
      if (o_msi_ack[p] === v) ok = 1'b1;
    end
  endtask

  task automatic send_msi(input int p, input logic [MIW-1:0] info);
    bit ok;
    i_msi_info[p*MIW +: MIW] = info;
    i_msi_req[p] = 1'b1;
    wait_ack(p, 1'b1, 12, ok);
    chk("ack_rise", 64'(ok), 64'd1);
    i_msi_req[p] = 1'b0;
    wait_ack(p, 1'b0, 12, ok);
    chk("ack_fall", 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    clear_model();
    tick(1);
  endtask

  initial begin
    bit ok;
    int a0, a1, peak;

    rstn = 1'b0; hart_id = 2'd1; i_msi_req = '0; i_msi_info = '0;
    i_claim_vld = 1'b0; i_claim_file = '0; i_claim_id = '0;
    i_sw_wr = '0; i_sw_data = '0;
    clear_model();

    // Reset state
    tick(3);
    chk("rst_ack", 64'(o_msi_ack), 64'd0);
    chk("rst_fifo_cnt", 64'(o_fifo_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
    check_eip("rst_eip");
    rstn = 1'b1;
    tick(1);

    // Single MSI, ack latency and eip placement
    i_msi_info[0 +: MIW] = msi(1, 1, 70);
    i_msi_req[0] = 1'b1;
    wait_ack(0, 1'b1, 4, ok);
    chk("single_ack_latency", 64'(ok), 64'd1);
    i_msi_req[0] = 1'b0;
    wait_ack(0, 1'b0, 12, ok);
    chk("single_ack_fall", 64'(ok), 64'd1);
    exp_reg[5] = 64'h40;
    chk("single_reg5", o_eip[5*64 +: 64], 64'h40);
    check_eip("single_eip");

    // Simultaneous requests from pointer 0; pops held off by a claim of id 0
    do_reset();
    i_claim_vld = 1'b1; i_claim_file = 3'd0; i_claim_id = 8'd0;
    i_msi_info[0 +: MIW]   = msi(1, 2, 3);
    i_msi_info[MIW +: MIW] = msi(1, 2, 4);
    i_msi_req = 2'b11;
    a0 = 0; a1 = 0; peak = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (o_msi_ack[0] === 1'b1 && a0 == 0) a0 = c;
      if (o_msi_ack[1] === 1'b1 && a1 == 0) a1 = c;
      if (int'(o_fifo_cnt) > peak) peak = int'(o_fifo_cnt);
    end
    chk("rr_port0_ack_cycle", 64'(a0), 64'd3);
    chk("rr_port1_after_port0", 64'(a1 - a0), 64'd1);
    chk("rr_fifo_peak", 64'(peak), 64'd2);
    i_claim_vld = 1'b0;
    i_msi_req = 2'b00;
    tick(8);
    chk("rr_fifo_drained", 64'(o_fifo_cnt), 64'd0);
    chk("rr_acks_low", 64'(o_msi_ack), 64'd0);
    exp_reg[8] = 64'h18;
    check_eip("rr_eip");

    // Back-pressure: full FIFO withholds the fifth ack until pops resume
    i_claim_vld = 1'b1;
    for (int k = 0; k < 4; k++) send_msi(0, msi(1, 0, 10 + k));
    i_msi_info[0 +: MIW] = msi(1, 0, 14);
    i_msi_req[0] = 1'b1;
    wait_ack(0, 1'b1, 20, ok);
    chk("full_fifth_blocked", 64'(ok), 64'd0);
    chk("full_fifo_cnt", 64'(o_fifo_cnt), 64'd4);
    check_eip("full_eip_unchanged");
    i_claim_vld = 1'b0;
    wait_ack(0, 1'b1, 12, ok);
    chk("full_fifth_acked", 64'(ok), 64'd1);
    i_msi_req[0] = 1'b0;
    wait_ack(0, 1'b0, 12, ok);
    tick(4);
    exp_reg[0] = 64'h7C00;
    check_eip("full_eip_all5");
    chk("full_fifo_empty", 64'(o_fifo_cnt), 64'd0);

    // Invalid MSIs are dropped and counted, saturating
    send_msi(0, msi(0, 1, 5));
    send_msi(1, msi(1, 7, 5));
    tick(2);
    chk("drop_two", 64'(o_drop_cnt), 64'd2);
    check_eip("drop_eip_unchanged");
    for (int i = 0; i < 300; i++) begin
      case (i % 3)
        0:       send_msi(i % 2, msi(2, 1, 5));
        1:       send_msi(i % 2, msi(1, 7, 9));
        default: send_msi(i % 2, msi(1, 2, 0));
      endcase
    end
    tick(2);
    chk("drop_saturated", 64'(o_drop_cnt), 64'd255);
    check_eip("drop_eip_after_sat");

    // Software write and claim in the same cycle: write first, then claim clears
    i_sw_data[5*64 +: 64] = 64'hFF;
    i_sw_wr[5] = 1'b1;
    i_claim_vld = 1'b1; i_claim_file = 3'd1; i_claim_id = 8'd70;
    tick(1);
    i_sw_wr = '0; i_claim_vld = 1'b0;
    exp_reg[5] = 64'hBF;
    chk("swclaim_reg5", o_eip[5*64 +: 64], 64'hBF);
    i_claim_vld = 1'b1; i_claim_file = 3'd7; i_claim_id = 8'd64;
    tick(1);
    i_claim_vld = 1'b0;
    chk("claim_file7_ignored", o_eip[5*64 +: 64], 64'hBF);
    i_claim_vld = 1'b1; i_claim_file = 3'd1; i_claim_id = 8'd71;
    tick(1);
    i_claim_vld = 1'b0;
    exp_reg[5] = 64'h3F;
    chk("claim_bit71", o_eip[5*64 +: 64], 64'h3F);
    check_eip("swclaim_eip");

    // Reset with port0 in ACK and two entries queued; held req is re-delivered
    i_claim_vld = 1'b1; i_claim_file = 3'd0; i_claim_id = 8'd0;
    send_msi(0, msi(1, 3, 32));
    i_msi_info[0 +: MIW] = msi(1, 3, 33);
    i_msi_req[0] = 1'b1;
    wait_ack(0, 1'b1, 12, ok);
    chk("rst2_ack_before", 64'(ok), 64'd1);
    chk("rst2_fifo_before", 64'(o_fifo_cnt), 64'd2);
    rstn = 1'b0;
    #2;
    clear_model();
    chk("rst2_ack_cleared", 64'(o_msi_ack), 64'd0);
    chk("rst2_fifo_cleared", 64'(o_fifo_cnt), 64'd0);
    check_eip("rst2_eip_cleared");
    tick(2);
    rstn = 1'b1;
    i_claim_vld = 1'b0;
    wait_ack(0, 1'b1, 12, ok);
    chk("rst2_reacked", 64'(ok), 64'd1);
    i_msi_req[0] = 1'b0;
    wait_ack(0, 1'b0, 12, ok);
    chk("rst2_ack_fall", 64'(ok), 64'd1);
    exp_reg[12] = 64'h2_0000_0000;
    check_eip("rst2_eip_repushed");
    chk("rst2_drop_cnt", 64'(o_drop_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
